ram_port_arbiter: RTL and testbench

//  Shares one single-port RAM (DEP x WID, ram.v) between two requesters, A and B.

---
 rtl/ram_port_arbiter_pkg.sv | 15 +
 rtl/ram_port_arbiter_rr_arb2.sv | 29 ++
 rtl/ram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-client RAM port arbiter: controller states and
// parameter defaults.
package ram_port_arbiter_pkg;

  localparam int unsigned DEP_DEF   = 64;
  localparam int unsigned WID_DEF   = 16;
  localparam int unsigned ADD_W_DEF = 6;
  localparam logic [15:0] INIT_VAL_DEF = 16'h0000;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational, and the priority pointer
// flips to the other side after every grant.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // 0: A wins a tie, 1: B wins a tie
  logic ptr_b_q, ptr_b_d;

  always_comb begin
    gnt_a   = en && req_a && (!req_b || !ptr_b_q);
    gnt_b   = en && req_b && (!req_a ||  ptr_b_q);
    ptr_b_d = ptr_b_q;
    if (gnt_a)      ptr_b_d = 1'b1;
    else if (gnt_b) ptr_b_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_b_q <= 1'b0;
    else        ptr_b_q <= ptr_b_d;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between requesters A and B using round-robin arbitration.
// After reset, or when clr is raised, it runs a clear sweep that writes INIT_VAL to every word.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned     DEP      = DEP_DEF,
  parameter int unsigned     WID      = WID_DEF,
  parameter int unsigned     ADD_W    = ADD_W_DEF,
  parameter logic [WID-1:0]  INIT_VAL = WID'(INIT_VAL_DEF)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             a_req,
  input  logic             a_wr,
  input  logic [ADD_W-1:0] a_addr,
  input  logic [WID-1:0]   a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [WID-1:0]   a_rdata,
  input  logic             b_req,
  input  logic             b_wr,
  input  logic [ADD_W-1:0] b_addr,
  input  logic [WID-1:0]   b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WID-1:0]   b_rdata,
  output logic             ram_wr,
  output logic [ADD_W-1:0] ram_addr,
  output logic [WID-1:0]   ram_din,
  input  logic [WID-1:0]   ram_dout,
  output logic             busy
);

  localparam logic [ADD_W-1:0] CNT_LAST = ADD_W'(DEP - 1);

  state_e           state_q, state_d;
  logic [ADD_W-1:0] cnt_q, cnt_d;
  logic [ADD_W-1:0] addr_q, addr_d;
  logic [WID-1:0]   din_q, din_d;
  logic             a_rvalid_q, a_rvalid_d;
  logic             b_rvalid_q, b_rvalid_d;
  logic [WID-1:0]   a_rdata_q, a_rdata_d;
  logic [WID-1:0]   b_rdata_q, b_rdata_d;
  logic             sweep;
  logic             serve_en;

  // Sweep writes are qualified by rstn so the RAM port stays quiet while reset is held.
  assign sweep    = (state_q == ST_INIT) && rstn;
  assign serve_en = (state_q == ST_SERVE) && !clr;
  assign busy     = (state_q == ST_INIT);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rstn),
    .en    (serve_en),
    .req_a (a_req),
    .req_b (b_req),
    .gnt_a (a_gnt),
    .gnt_b (b_gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SERVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SERVE: begin
        if (clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    ram_wr   = 1'b0;
    ram_addr = addr_q;
    ram_din  = din_q;
    if (sweep) begin
      ram_wr   = 1'b1;
      ram_addr = cnt_q;
      ram_din  = INIT_VAL;
    end else if (a_gnt) begin
      ram_wr   = a_wr;
      ram_addr = a_addr;
      ram_din  = a_wdata;
    end else if (b_gnt) begin
      ram_wr   = b_wr;
      ram_addr = b_addr;
      ram_din  = b_wdata;
    end
    addr_d = ram_addr;
    din_d  = ram_din;
  end

  // RAM output is live only during the valid cycle; the held copy covers the rest.
  always_comb begin
    a_rvalid_d = a_gnt && !a_wr;
    b_rvalid_d = b_gnt && !b_wr;
    a_rvalid   = a_rvalid_q;
    b_rvalid   = b_rvalid_q;
    a_rdata    = a_rvalid_q ? ram_dout : a_rdata_q;
    b_rdata    = b_rvalid_q ? ram_dout : b_rdata_q;
    a_rdata_d  = a_rdata;
    b_rdata_d  = b_rdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with an attached single-port RAM; a transaction-level
// model of memory contents, arbitration and read returns predicts every output.
module tb_ram_port_arbiter;

  localparam int DEP   = 64;
  localparam int WID   = 16;
  localparam int ADD_W = 6;
  localparam logic [WID-1:0] INIT_VAL = 16'h0000;

  logic             clk = 1'b0;
  logic             rstn, clr;
  logic             a_req, a_wr, b_req, b_wr;
  logic [ADD_W-1:0] a_addr, b_addr, ram_addr;
  logic [WID-1:0]   a_wdata, b_wdata, a_rdata, b_rdata, ram_din, ram_dout;
  logic             a_gnt, b_gnt, a_rvalid, b_rvalid, ram_wr, busy;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DEP(DEP), .WID(WID), .ADD_W(ADD_W), .INIT_VAL(INIT_VAL)) dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  // Single-port RAM with one-cycle registered read
  logic [WID-1:0] ram_mem [DEP];
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [WID-1:0] ref_mem [DEP];
  int             sweep_left;
  bit             last_b;
  bit             pa_v, pb_v;
  logic [WID-1:0] pa_d, pb_d, ha, hb;
  int             obs_a_gnts, obs_b_gnts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_a_gnt", a_gnt, 0);       chk("rst_b_gnt", b_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0); chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);   chk("rst_b_rdata", b_rdata, 0);
    chk("rst_ram_wr", ram_wr, 0);     chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);   chk("rst_busy", busy, 1);
    sweep_left = DEP;
    last_b = 1'b1;
    pa_v = 1'b0; pb_v = 1'b0;
    ha = '0; hb = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  // One clock cycle: drive inputs, predict and check, then advance the model.
  task automatic cycle(input bit ar, input bit aw, input logic [ADD_W-1:0] aa,
                       input logic [WID-1:0] ad, input bit br, input bit bw,
                       input logic [ADD_W-1:0] ba, input logic [WID-1:0] bd, input bit c);
    bit ga, gb, ewr, active;
    logic [ADD_W-1:0] eaddr;
    logic [WID-1:0] edin;
    a_req = ar; a_wr = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_wr = bw; b_addr = ba; b_wdata = bd;
    clr = c;
    ga = 0; gb = 0; ewr = 0; eaddr = '0; edin = '0;
    if (sweep_left > 0) begin
      ewr = 1; eaddr = ADD_W'(DEP - sweep_left); edin = INIT_VAL;
    end else if (!c) begin
      if (ar && br) begin ga = last_b; gb = !last_b; end
      else begin ga = ar; gb = br; end
      if (ga)      begin ewr = aw; eaddr = aa; edin = ad; end
      else if (gb) begin ewr = bw; eaddr = ba; edin = bd; end
    end
    active = ga || gb || (sweep_left > 0);
    @(negedge clk);
    chk("busy", busy, (sweep_left > 0) ? 1 : 0);
    chk("a_gnt", a_gnt, ga);
    chk("b_gnt", b_gnt, gb);
    chk("ram_wr", ram_wr, ewr);
    if (active) chk("ram_addr", ram_addr, eaddr);
    if (ewr)    chk("ram_din", ram_din, edin);
    chk("a_rvalid", a_rvalid, pa_v);
    chk("b_rvalid", b_rvalid, pb_v);
    chk("a_rdata", a_rdata, pa_v ? pa_d : ha);
    chk("b_rdata", b_rdata, pb_v ? pb_d : hb);
    obs_a_gnts += int'(a_gnt === 1'b1);
    obs_b_gnts += int'(b_gnt === 1'b1);
    @(posedge clk); #1;
    if (pa_v) ha = pa_d;
    if (pb_v) hb = pb_d;
    pa_v = 0; pb_v = 0;
    if (sweep_left > 0) begin
      ref_mem[eaddr] = INIT_VAL;
      sweep_left--;
    end else if (c) begin
      sweep_left = DEP;
    end else if (ga) begin
      last_b = 0;
      if (aw) ref_mem[aa] = ad; else begin pa_v = 1; pa_d = ref_mem[aa]; end
    end else if (gb) begin
      last_b = 1;
      if (bw) ref_mem[ba] = bd; else begin pb_v = 1; pb_d = ref_mem[ba]; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    clr = 0; a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    obs_a_gnts = 0; obs_b_gnts = 0;

    // 1: reset, sweep, reads of the end words
    do_reset();
    idle(DEP);
    cycle(1, 0, 6'd0,  '0, 0, 0, '0, '0, 0);
    cycle(1, 0, 6'd63, '0, 0, 0, '0, '0, 0);
    idle(1);

    // 2: write then read on consecutive cycles
    cycle(1, 1, 6'd0, 16'hFFFF, 0, 0, '0, '0, 0);
    cycle(1, 0, 6'd0, '0,       0, 0, '0, '0, 0);
    cycle(0, 0, '0, '0, 1, 1, 6'd63, 16'h0000, 0);
    cycle(0, 0, '0, '0, 1, 0, 6'd63, '0,       0);
    idle(1);

    // 3: both sides requesting every cycle
    obs_a_gnts = 0; obs_b_gnts = 0;
    for (int i = 0; i < 8; i++)
      cycle(1, 1'($urandom_range(1)), ADD_W'($urandom), WID'($urandom),
            1, 1'($urandom_range(1)), ADD_W'($urandom), WID'($urandom), 0);
    chk("t3_a_grants", obs_a_gnts, 4);
    chk("t3_b_grants", obs_b_gnts, 4);
    idle(1);

    // 4: A streams writes then reads over the whole array
    for (int i = 0; i < DEP; i++) cycle(1, 1, ADD_W'(i), WID'($urandom), 0, 0, '0, '0, 0);
    for (int i = 0; i < DEP; i++) cycle(1, 0, ADD_W'(i), '0, 0, 0, '0, '0, 0);
    idle(1);

    // 5: clr right after an A read grant
    cycle(1, 0, 6'd5, '0, 0, 0, '0, '0, 0);
    cycle(1, 0, 6'd6, '0, 1, 0, 6'd7, '0, 1);
    idle(DEP);
    cycle(1, 0, ADD_W'($urandom), '0, 0, 0, '0, '0, 0);
    cycle(0, 0, '0, '0, 1, 0, ADD_W'($urandom), '0, 0);
    idle(1);

    // 6: reset in the middle of a stream, with a read outstanding at i==7
    for (int i = 0; i < 16; i++) begin
      cycle(1, (i % 2) == 0, ADD_W'(i), WID'($urandom),
            i > 8, 1'($urandom_range(1)), ADD_W'($urandom), WID'($urandom), 0);
      if (i == 7) begin
        do_reset();
        idle(DEP);
      end
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
